// File: rtl/tdot_pkg.sv
// Shared types for the dot-product MAC sequencer: FSM states, accumulate-select
// encodings and the tag that travels alongside each beat through the slice pipeline.
package tdot_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic SEL_C = 1'b0;  // P = A*B + C
    localparam logic SEL_P = 1'b1;  // P = A*B + P

    // Tag field widths cover the default slice configuration (W = 8, LEN_W = 8).
    localparam int TAG_C_W   = 8;
    localparam int TAG_LEN_W = 8;

    typedef struct packed {
        logic                 sel;
        logic [TAG_C_W-1:0]   c;
        logic                 last;
        logic [TAG_LEN_W-1:0] len;
    } tag_t;

endpackage

// File: rtl/tdot_mac_sched_if.sv
// Operand-beat input stream and dot-product result output stream of the MAC sequencer.
interface tdot_mac_sched_if #(
    parameter int W     = 8,
    parameter int LEN_W = 8
);
    // Both streams transfer on a cycle where valid & ready are high; a source holds
    // valid and its payload stable until the transfer. s_ready may depend on s_last.
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_a;
    logic [W-1:0]     s_b;
    logic [W-1:0]     s_c;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_y;
    logic [LEN_W-1:0] m_len;

    modport master (
        output s_valid, s_a, s_b, s_c, s_last, m_ready,
        input  s_ready, m_valid, m_y, m_len
    );

    modport slave (
        input  s_valid, s_a, s_b, s_c, s_last, m_ready,
        output s_ready, m_valid, m_y, m_len
    );

endinterface

// File: rtl/tdot_delay.sv
// Fixed-depth shift register with asynchronous active-low clear; q is d delayed DEPTH cycles.
module tdot_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] line_q;
    logic [DEPTH-1:0][WIDTH-1:0] line_d;

    always_comb begin
        line_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            line_d[i] = line_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign q = line_q[DEPTH-1];

endmodule

// File: rtl/tdot_mac_sched.sv
// Drives one pipelined DSP MAC slice to compute arbitrary-length dot products from an
// operand stream, including the post-reset hold of the slice and result capture.
module tdot_mac_sched
    import tdot_pkg::*;
#(
    parameter int W          = 8,
    parameter int MAC_LAT    = 3,
    parameter int RST_CYCLES = 3,
    parameter int LEN_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    tdot_mac_sched_if.slave bus,
    output logic          mac_rst,
    output logic          mac_en,
    output logic [W-1:0]  mac_a,
    output logic [W-1:0]  mac_b,
    output logic [W-1:0]  mac_c,
    output logic          mac_sel,
    input  logic [W-1:0]  mac_p,
    output state_t        dbg_state
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             mac_rst_q, mac_rst_d;
    logic             mac_en_q, mac_en_d;
    logic             first_q, first_d;
    logic             pending_q, pending_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [W-1:0]     m_y_q, m_y_d;
    logic [LEN_W-1:0] m_len_q, m_len_d;

    logic                 s_ready;
    logic                 acc;
    logic [LEN_W-1:0]     len_now;
    tag_t                 tag_in;
    logic [TAG_C_W:0]     selc_out;
    logic [TAG_LEN_W:0]   lastlen_out;

    // A second last beat must wait until the held result is consumed.
    assign s_ready = (state_q == RUN) & ~(bus.s_last & pending_q);
    assign acc     = bus.s_valid & s_ready;

    always_comb begin
        len_now = first_q ? LEN_W'(1) : ((cnt_q == LEN_MAX) ? cnt_q : cnt_q + 1'b1);
        tag_in     = '0;
        tag_in.sel = SEL_P;
        if (acc) begin
            tag_in.sel  = first_q ? SEL_C : SEL_P;
            tag_in.c    = TAG_C_W'(bus.s_c);
            tag_in.last = bus.s_last;
            tag_in.len  = TAG_LEN_W'(len_now);
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        mac_rst_d = mac_rst_q;
        mac_en_d  = mac_en_q;
        case (state_q)
            INIT: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d   = RUN;
                    mac_rst_d = 1'b0;
                    mac_en_d  = 1'b1;
                end
            end
            RUN: begin
                mac_rst_d = 1'b0;
                mac_en_d  = 1'b1;
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        first_d   = acc ? bus.s_last : first_q;
        cnt_d     = acc ? len_now : cnt_q;
        pending_d = pending_q;
        if (m_valid_q & bus.m_ready) pending_d = 1'b0;
        if (acc & bus.s_last)        pending_d = 1'b1;
        m_valid_d = m_valid_q;
        m_y_d     = m_y_q;
        m_len_d   = m_len_q;
        // The last tag emerges in the cycle the slice's P register holds the final sum.
        if (lastlen_out[TAG_LEN_W]) begin
            m_valid_d = 1'b1;
            m_y_d     = mac_p;
            m_len_d   = LEN_W'(lastlen_out[TAG_LEN_W-1:0]);
        end else if (m_valid_q & bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            rst_cnt_q <= '0;
            mac_rst_q <= 1'b1;
            mac_en_q  <= 1'b0;
            first_q   <= 1'b1;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_y_q     <= '0;
            m_len_q   <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            mac_rst_q <= mac_rst_d;
            mac_en_q  <= mac_en_d;
            first_q   <= first_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_y_q     <= m_y_d;
            m_len_q   <= m_len_d;
        end
    end

    // sel/c must line up with the M stage; last/len with the P stage.
    tdot_delay #(.WIDTH(TAG_C_W + 1), .DEPTH(MAC_LAT - 1)) u_selc_dly (
        .clk   (clk),
        .rst_n (reset),
        .d     ({tag_in.sel, tag_in.c}),
        .q     (selc_out)
    );

    tdot_delay #(.WIDTH(TAG_LEN_W + 1), .DEPTH(MAC_LAT)) u_last_dly (
        .clk   (clk),
        .rst_n (reset),
        .d     ({tag_in.last, tag_in.len}),
        .q     (lastlen_out)
    );

    assign mac_a       = acc ? bus.s_a : '0;
    assign mac_b       = acc ? bus.s_b : '0;
    assign mac_sel     = selc_out[TAG_C_W];
    assign mac_c       = W'(selc_out[TAG_C_W-1:0]);
    assign mac_rst     = mac_rst_q;
    assign mac_en      = mac_en_q;
    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_y     = m_y_q;
    assign bus.m_len   = m_len_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_tdot_mac_sched.sv
// Scoreboard bench for tdot_mac_sched with a behavioural model of the 3-stage MAC slice.
module tb_tdot_mac_sched;
    import tdot_pkg::*;

    localparam int W     = 8;
    localparam int LEN_W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mac_rst, mac_en, mac_sel;
    logic [W-1:0] mac_a, mac_b, mac_c, mac_p;
    state_t       dbg_state;

    tdot_mac_sched_if #(.W(W), .LEN_W(LEN_W)) bus ();

    tdot_mac_sched #(.W(W), .MAC_LAT(3), .RST_CYCLES(3), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mac_rst   (mac_rst),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_sel   (mac_sel),
        .mac_p     (mac_p),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DSP slice model: operand regs -> M reg -> P reg, synchronous reset, CE on all stages
    logic [W-1:0]   sl_a, sl_b, sl_p;
    logic [2*W-1:0] sl_m;
    always @(posedge clk) begin
        if (mac_rst) begin
            sl_a <= '0; sl_b <= '0; sl_m <= '0; sl_p <= '0;
        end else if (mac_en) begin
            sl_a <= mac_a;
            sl_b <= mac_b;
            sl_m <= sl_a * sl_b;
            sl_p <= sl_m[W-1:0] + (mac_sel ? sl_p : mac_c);
        end
    end
    assign mac_p = sl_p;

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [W+LEN_W-1:0] exp_q[$];
    int lat_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic prev_mv = 1'b0;
    always @(negedge clk) begin
        if (bus.m_valid && !prev_mv) begin
            if (lat_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_m_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                check("latency", cyc - lat_q.pop_front(), 4);
            end
        end
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_result: got m_y=%0d expected none", bus.m_y);
            end else begin
                logic [W+LEN_W-1:0] e;
                e = exp_q.pop_front();
                check("m_y", bus.m_y, e[W+LEN_W-1:LEN_W]);
                check("m_len", bus.m_len, e[LEN_W-1:0]);
            end
        end
        prev_mv = bus.m_valid;
    end

    // drivers
    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic last, input logic [W-1:0] ey, input logic [LEN_W-1:0] el);
        bus.s_valid = 1'b1;
        bus.s_a = a; bus.s_b = b; bus.s_c = c; bus.s_last = last;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                if (last) begin
                    exp_q.push_back({ey, el});
                    lat_q.push_back(cyc);
                end
                @(posedge clk); #1;
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_cmp++; n_err++;
        $display("FAIL send_timeout: got no s_ready expected accept within 50 cycles");
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic check_init();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("init_mac_rst", mac_rst, (k < 3) ? 1 : 0);
            check("init_mac_en", mac_en, (k == 3) ? 1 : 0);
            check("init_s_ready", bus.s_ready, (k == 3) ? 1 : 0);
            check("init_m_valid", bus.m_valid, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.s_valid = 0; bus.s_a = 0; bus.s_b = 0; bus.s_c = 0; bus.s_last = 0;
        bus.m_ready = 1;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dbg_state, INIT);
        check("rst_mac_rst", mac_rst, 1);
        check("rst_mac_en", mac_en, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_y", bus.m_y, 0);
        check("rst_m_len", bus.m_len, 0);
        reset = 1;
        check_init();
        idle(2);

        // 1*4 + 2*5 + 3*6 + 7 = 39, back-to-back
        send(1, 4, 7, 0, 0, 0);
        send(2, 5, 7, 0, 0, 0);
        send(3, 6, 7, 1, 39, 3);
        idle(8);

        // same vector with two bubbles after beat 1
        send(1, 4, 7, 0, 0, 0);
        @(negedge clk);
        check("bubble_mac_a", mac_a, 0);
        check("bubble_mac_b", mac_b, 0);
        check("bubble_sel_idle", mac_sel, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bubble2_mac_a", mac_a, 0);
        check("bubble2_mac_b", mac_b, 0);
        check("first_beat_sel", mac_sel, 0);
        check("first_beat_c", mac_c, 7);
        @(posedge clk); #1;
        @(negedge clk);
        check("bubble_tag_sel", mac_sel, 1);
        @(posedge clk); #1;
        send(2, 5, 7, 0, 0, 0);
        send(3, 6, 7, 1, 39, 3);
        idle(8);

        // held result blocks the next vector's last beat
        bus.m_ready = 0;
        send(2, 3, 1, 1, 7, 1);
        send(10, 10, 0, 0, 0, 0);
        bus.s_valid = 1; bus.s_a = 20; bus.s_b = 20; bus.s_c = 0; bus.s_last = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("blocked_s_ready", bus.s_ready, 0);
            @(posedge clk); #1;
        end
        check("held_m_valid", bus.m_valid, 1);
        check("held_m_y", bus.m_y, 7);
        check("held_m_len", bus.m_len, 1);
        bus.m_ready = 1;
        send(20, 20, 0, 1, 244, 2);
        idle(8);

        // single beat, wrap mod 256
        send(255, 255, 1, 1, 2, 1);
        idle(8);

        // 257 beats of 1*1: sum wraps to 1, length saturates at 255
        for (int i = 0; i < 257; i++) begin
            send(1, 1, 0, (i == 256), 1, 255);
        end
        idle(8);

        // reset during beat 2 of a 3-beat vector
        send(1, 1, 0, 0, 0, 0);
        bus.s_valid = 1; bus.s_a = 2; bus.s_b = 2; bus.s_c = 0; bus.s_last = 0;
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        bus.s_valid = 0;
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_mac_rst", mac_rst, 1);
        check("midrst_state", dbg_state, INIT);
        @(posedge clk); #1;
        reset = 1;
        check_init();
        send(3, 3, 2, 0, 0, 0);
        send(4, 4, 2, 1, 27, 2);

        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdot_mac_sched.md
Name: tdot_mac_sched

Overview:
- Sequencer that time-multiplexes one pipelined DSP multiply-accumulate slice to compute dot products of arbitrary length.
- Operand pairs arrive as a valid/ready stream. The block drives the slice's operands, clock-enable, reset and accumulate-select, aligned to the slice's pipeline.
- It captures each finished sum into an output register with a valid/ready handshake.
- It also performs the post-reset reset hold of the slice, so no external counter is needed.

Parameters:
- W, 8, operand/result width (result is mod 2^W).
- MAC_LAT, 3, slice latency: operand reg -> M reg -> P reg.
- RST_CYCLES, 3, cycles mac_rst stays high after reset release.
- LEN_W, 8, width of beat counter m_len.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat accepted when s_valid&s_ready.
- s_a  in  W  operand a.
- s_b  in  W  operand b.
- s_c  in  W  bias, sampled on first beat of a vector only.
- s_last  in  1  final beat of vector.
- mac_rst  out  1  slice reset (all RST pins).
- mac_en  out  1  slice CE (all register stages).
- mac_a  out  W  slice A operand.
- mac_b  out  W  slice B operand.
- mac_c  out  W  slice C operand.
- mac_sel  out  1  0: P=A*B+C; 1: P=A*B+P.
- mac_p  in  W  slice P output (low W bits).
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed.
- m_y  out  W  dot product result.
- m_len  out  LEN_W  beats in the vector (saturates at all-ones).

Behaviour:
- Reset asserted (reset=0): state=INIT, rst_cnt=0, mac_rst=1, mac_en=0, s_ready=0, m_valid=0, m_y=0, m_len=0, first=1, pending=0, all delay lines cleared.
- INIT: mac_rst=1, rst_cnt increments each cycle; at rst_cnt==RST_CYCLES-1 -> RUN. Exactly RST_CYCLES cycles with mac_rst=1 after release.
- RUN: mac_rst=0, mac_en=1 every cycle. The slice is never stalled; bubbles are inserted instead.
- s_ready = RUN & ~(s_last & pending). Ready depends on s_last by design; the bench must not require it independent of data.
- Accepted beat in cycle t: mac_a=s_a, mac_b=s_b combinationally. Tag {sel = first?0:1, c = s_c, last = s_last} enters the delay line.
- No accepted beat: mac_a=mac_b=0, tag sel=1, last=0 (accumulates 0, harmless).
- mac_sel and mac_c are the tag delayed MAC_LAT-1 cycles (valid in cycle t+2 while M holds the product).
- The last flag is delayed MAC_LAT cycles. When it emerges (cycle t+3), m_y<=mac_p and m_len<=beat count at edge end of t+3. m_valid=1 from cycle t+4.
- Latency: last-beat accept to m_valid = MAC_LAT+1 = 4 cycles. Single-beat vector yields a*b+c.
- first: set after reset and after accepting a last beat; cleared on accepting a non-last beat.
- Beat counter: reset to 1 on a first beat, otherwise increments and saturates. The value is carried with the last tag into m_len.
- pending: set on accepting a last beat; cleared on m_valid&m_ready. Simultaneous set and clear -> remains 1.
- Non-last beats of the next vector are accepted while pending; the accumulator restarts via sel=0, independent of the held result.
- m_valid stays high and m_y, m_len stay stable until m_ready.
- Overflow wraps mod 2^W. Width mismatch is silent truncation.
- Reset mid-vector: all in-flight tags and results are discarded, the INIT sequence reruns, and the partial vector is lost.

Decomposition:
- Package tdot_pkg: state enum {INIT, RUN}; SEL_C=0 and SEL_P=1 constants; tag struct {sel, c, last, len}.
- Sub-module tdot_delay: parameterised-depth shift register with async active-low clear, used for the sel/c and last/len tag lines.

Test Plan:
- Reset released at cycle 0 -> mac_rst high cycles 0..2, s_ready first high cycle 3, m_valid=0 throughout.
- W=8, beats (1,4),(2,5),(3,6), c=7, back-to-back -> m_y=39, m_len=3, m_valid 4 cycles after last accept.
- Same vector with s_valid low for 2 cycles between beats 1 and 2 -> m_y=39, m_len=3, mac_a=mac_b=0 and mac_sel=1 during bubbles.
- Two vectors back-to-back: (2,3) c=1 last, then (10,10),(20,20) c=0 with m_ready=0 -> m_y=7 held; second last beat blocked (s_ready=0) until m_ready=1; then m_y=244 (500 mod 256), m_len=2.
- Single beat (255,255) c=1 -> m_y=2 (65026 mod 256).
- reset pulsed low during beat 2 of a 3-beat vector -> no m_valid for that vector, INIT rerun, next vector correct.
